div_clk_monitor: RTL

//  Checks a divided clock (e.g. the divide-by-2 output) against the fast clock it came from.

---
 rtl/div_mon_pkg.sv | 17 +
 rtl/mon_edge_det.sv | 55 +++++
 rtl/div_clk_monitor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock health monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        CHECK,
        LOCKED
    } mon_state_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mon_edge_det.sv
// Brings mon_clk into the in_clk domain as data and flags its rising edges.
module mon_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clk,
    input  logic reset_n,
    input  logic mon_clk,
    output logic s_q,
    output logic rise
);

    logic s_prev_q;
    logic s_prev_d;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s_q = mon_clk;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb begin
                sync_d[0] = mon_clk;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge in_clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s_q = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        s_prev_d = s_q;
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s_prev_d;
        end
    end

    assign rise = s_q & ~s_prev_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock in in_clk cycles and
// reports lock, period/duty errors and stuck-clock timeouts.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int DIV_RATIO   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 8
) (
    input  logic                 in_clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 mon_clk,
    output logic                 locked,
    output logic                 meas_valid,
    output logic [CNT_W-1:0]     period_meas,
    output logic [CNT_W-1:0]     high_meas,
    output logic                 period_err,
    output logic                 stuck_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic s_q;
    logic rise;

    mon_state_e state_q, state_d;
    logic [CNT_W-1:0]     per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]     hi_cnt_q, hi_cnt_d;
    logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
    logic                 locked_q, locked_d;
    logic                 meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]     period_meas_q, period_meas_d;
    logic [CNT_W-1:0]     high_meas_q, high_meas_d;
    logic                 period_err_q, period_err_d;
    logic                 stuck_err_q, stuck_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 good_period;
    logic                 timeout;
    logic [GOOD_W-1:0]    good_inc;
    logic [CNT_W-1:0]     per_next;
    logic [CNT_W-1:0]     hi_next;

    mon_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .in_clk (in_clk),
        .reset_n(reset_n),
        .mon_clk(mon_clk),
        .s_q    (s_q),
        .rise   (rise)
    );

    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        good_cnt_d    = good_cnt_q;
        meas_valid_d  = 1'b0;
        period_err_d  = 1'b0;
        stuck_err_d   = 1'b0;
        period_meas_d = period_meas_q;
        high_meas_d   = high_meas_q;
        err_count_d   = err_count_q;

        good_period = (per_cnt_q == CNT_W'(DIV_RATIO)) && (hi_cnt_q == CNT_W'(DIV_RATIO / 2));
        timeout     = (per_cnt_q >= CNT_W'(TIMEOUT));
        good_inc    = good_cnt_q + 1'b1;
        per_next    = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
        hi_next     = (s_q && (hi_cnt_q != CNT_MAX)) ? hi_cnt_q + 1'b1 : hi_cnt_q;

        if (!en) begin
            state_d    = IDLE;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ACQUIRE;
                    per_cnt_d  = '0;
                    hi_cnt_d   = '0;
                    good_cnt_d = '0;
                end
                default: begin
                    // A rise closes the running period; it takes priority over a timeout.
                    if (rise) begin
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        if (state_q == ACQUIRE) begin
                            state_d = CHECK;
                        end else begin
                            meas_valid_d  = 1'b1;
                            period_meas_d = per_cnt_q;
                            high_meas_d   = hi_cnt_q;
                            if (good_period) begin
                                if (state_q == CHECK) begin
                                    good_cnt_d = good_inc;
                                    if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                                        state_d = LOCKED;
                                    end
                                end
                            end else begin
                                period_err_d = 1'b1;
                                good_cnt_d   = '0;
                                state_d      = CHECK;
                            end
                        end
                    end else if (timeout) begin
                        stuck_err_d = 1'b1;
                        state_d     = ACQUIRE;
                        per_cnt_d   = '0;
                        hi_cnt_d    = '0;
                        good_cnt_d  = '0;
                    end else begin
                        per_cnt_d = per_next;
                        hi_cnt_d  = hi_next;
                    end
                end
            endcase
        end

        if (period_err_d || stuck_err_d) begin
            err_count_d = err_inc(err_count_q);
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            good_cnt_q    <= '0;
            locked_q      <= 1'b0;
            meas_valid_q  <= 1'b0;
            period_meas_q <= '0;
            high_meas_q   <= '0;
            period_err_q  <= 1'b0;
            stuck_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            good_cnt_q    <= good_cnt_d;
            locked_q      <= locked_d;
            meas_valid_q  <= meas_valid_d;
            period_meas_q <= period_meas_d;
            high_meas_q   <= high_meas_d;
            period_err_q  <= period_err_d;
            stuck_err_q   <= stuck_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign locked      = locked_q;
    assign meas_valid  = meas_valid_q;
    assign period_meas = period_meas_q;
    assign high_meas   = high_meas_q;
    assign period_err  = period_err_q;
    assign stuck_err   = stuck_err_q;
    assign err_count   = err_count_q;

endmodule
